// File: rtl/bus_pkg.sv
// Shared types for the data-bus arbiter: transfer type/size encodings and the
// arbiter FSM state.
package bus_pkg;

    typedef enum logic {
        READ  = 1'b0,
        WRITE = 1'b1
    } ttype_e;

    typedef enum logic [1:0] {
        BYTE     = 2'd0,
        HALFWORD = 2'd1,
        WORD     = 2'd2
    } tsize_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } arb_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first requester after last_grant, with
// wrap-around. The pointer register is owned by the caller.
module rr_arbiter #(
    parameter int N  = 2,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last_grant,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] grant_idx
);

    logic          found;
    logic [IW-1:0] idx;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = '0;
        // Offsets 1..N visit every master once, ending on last_grant itself.
        for (int i = 1; i <= N; i++) begin
            idx = IW'((int'(last_grant) + i) % N);
            if (!found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = idx;
            end
        end
    end

endmodule

// File: rtl/dbus_arbiter.sv
// Shares one slave bus port between NUM_MASTERS requesters with round-robin
// arbitration, a one-cycle bstart and a completion watchdog.
module dbus_arbiter
    import bus_pkg::*;
#(
    parameter int NUM_MASTERS    = 2,
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_MASTERS-1:0]        m_req,
    input  logic [NUM_MASTERS*ADDR_W-1:0] m_addr,
    input  logic [NUM_MASTERS-1:0]        m_ttype,
    input  logic [NUM_MASTERS*2-1:0]      m_tsize,
    input  logic [NUM_MASTERS*DATA_W-1:0] m_wdata,
    output logic [DATA_W-1:0]             m_rdata,
    output logic [NUM_MASTERS-1:0]        m_done,
    output logic                          m_err,
    output logic                          s_bstart,
    output logic [ADDR_W-1:0]             s_addr,
    output logic                          s_ttype,
    output logic [1:0]                    s_tsize,
    output logic [DATA_W-1:0]             s_wdata,
    input  logic [DATA_W-1:0]             s_rdata,
    input  logic                          s_done,
    output logic                          busy,
    output logic [1:0]                    dbg_state
);

    localparam int IW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
    localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CW-1:0] TO_LAST = CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    arb_state_e           state;
    logic [IW-1:0]        owner;
    logic [IW-1:0]        last_grant;
    logic [CW-1:0]        cnt;
    logic [NUM_MASTERS-1:0] win_grant;
    logic [IW-1:0]        win_idx;
    logic                 to_hit;
    logic                 fin;

    rr_arbiter #(
        .N  (NUM_MASTERS),
        .IW (IW)
    ) u_rr (
        .req        (m_req),
        .last_grant (last_grant),
        .grant      (win_grant),
        .grant_idx  (win_idx)
    );

    // s_done always beats a watchdog expiry landing in the same cycle.
    assign to_hit = (TIMEOUT_CYCLES != 0) && (cnt == TO_LAST);
    assign fin    = ((state == ISSUE) && s_done) ||
                    ((state == WAIT) && (s_done || to_hit));

    always_comb begin
        m_done  = '0;
        m_err   = 1'b0;
        m_rdata = '0;
        if (fin) begin
            m_done[owner] = 1'b1;
            m_err         = ~s_done;
            if (s_done) begin
                m_rdata = s_rdata;
            end
        end
    end

    assign busy      = (state != IDLE);
    assign dbg_state = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            s_bstart   <= 1'b0;
            s_addr     <= '0;
            s_wdata    <= '0;
            s_ttype    <= 1'b0;
            s_tsize    <= '0;
            owner      <= '0;
            last_grant <= IW'(NUM_MASTERS - 1);
            cnt        <= '0;
        end else begin
            s_bstart <= 1'b0;
            case (state)
                IDLE: begin
                    if (|win_grant) begin
                        s_addr   <= m_addr[win_idx*ADDR_W +: ADDR_W];
                        s_wdata  <= m_wdata[win_idx*DATA_W +: DATA_W];
                        s_ttype  <= m_ttype[win_idx];
                        s_tsize  <= m_tsize[win_idx*2 +: 2];
                        owner    <= win_idx;
                        s_bstart <= 1'b1;
                        state    <= ISSUE;
                    end
                end
                ISSUE: begin
                    cnt <= '0;
                    if (fin) begin
                        last_grant <= owner;
                        state      <= IDLE;
                    end else begin
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (fin) begin
                        last_grant <= owner;
                        state      <= IDLE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dbus_arbiter.sv
// Bench for dbus_arbiter: directed transactions, expected issues/completions
// queued up front and checked by an independent monitor.
`timescale 1ns/100ps
module tb_dbus_arbiter;
    import bus_pkg::*;

    localparam int N  = 2;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 4;

    logic            clk;
    logic            rst_n;
    logic [N-1:0]    m_req;
    logic [N*AW-1:0] m_addr;
    logic [N-1:0]    m_ttype;
    logic [N*2-1:0]  m_tsize;
    logic [N*DW-1:0] m_wdata;
    logic [DW-1:0]   m_rdata;
    logic [N-1:0]    m_done;
    logic            m_err;
    logic            s_bstart;
    logic [AW-1:0]   s_addr;
    logic            s_ttype;
    logic [1:0]      s_tsize;
    logic [DW-1:0]   s_wdata;
    logic [DW-1:0]   s_rdata;
    logic            s_done;
    logic            busy;
    logic [1:0]      dbg_state;

    logic slave_done;
    logic spur_done;
    int   slave_delay;
    assign s_done = slave_done | spur_done;

    // exp_q entry: {latency[7:0], m_done[1:0], m_err, m_rdata[31:0]}
    // bs_q entry:  {s_addr[31:0], s_ttype, s_tsize[1:0], s_wdata[31:0]}
    logic [42:0] exp_q[$];
    logic [66:0] bs_q[$];

    int   n_total;
    int   n_bad;
    int   cyc;
    int   bstart_cyc;
    logic prev_bstart;
    logic [42:0] e_item;
    logic [66:0] b_item;

    dbus_arbiter #(
        .NUM_MASTERS    (N),
        .ADDR_W         (AW),
        .DATA_W         (DW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .m_req     (m_req),
        .m_addr    (m_addr),
        .m_ttype   (m_ttype),
        .m_tsize   (m_tsize),
        .m_wdata   (m_wdata),
        .m_rdata   (m_rdata),
        .m_done    (m_done),
        .m_err     (m_err),
        .s_bstart  (s_bstart),
        .s_addr    (s_addr),
        .s_ttype   (s_ttype),
        .s_tsize   (s_tsize),
        .s_wdata   (s_wdata),
        .s_rdata   (s_rdata),
        .s_done    (s_done),
        .busy      (busy),
        .dbg_state (dbg_state)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", n_total, n_bad);
        $fatal(1);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic note_fail(input string name);
        n_total++;
        n_bad++;
        $display("FAIL %s: event not as expected at cycle %0d", name, cyc);
    endtask

    // driver tasks
    task automatic set_master(input int i, input logic [31:0] a, input ttype_e t,
                              input tsize_e s, input logic [31:0] w);
        m_addr[i*AW +: AW]  = a;
        m_ttype[i]          = t;
        m_tsize[i*2 +: 2]   = s;
        m_wdata[i*DW +: DW] = w;
    endtask

    task automatic expect_issue(input logic [31:0] a, input ttype_e t, input tsize_e s,
                                input logic [31:0] w);
        bs_q.push_back({a, t, s, w});
    endtask

    task automatic expect_done(input logic [7:0] lat, input logic [1:0] d, input logic e,
                               input logic [31:0] r);
        exp_q.push_back({lat, d, e, r});
    endtask

    task automatic wait_done(input logic [1:0] mask, input string name);
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if ((m_done & mask) != '0) return;
        end
        note_fail({name, "_no_done"});
    endtask

    task automatic wait_bstart(input string name);
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (s_bstart === 1'b1) return;
        end
        note_fail({name, "_no_bstart"});
    endtask

    // slave model: answers each bstart after slave_delay cycles (<0: never)
    initial begin
        slave_done = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (s_bstart === 1'b1 && slave_delay >= 0) begin
                repeat (slave_delay) @(posedge clk);
                #1 slave_done = 1'b1;
                @(posedge clk);
                #1 slave_done = 1'b0;
            end
        end
    end

    // scoreboard monitor
    initial begin
        prev_bstart = 1'b0;
        forever begin
            @(negedge clk);
            if (s_bstart === 1'b1) begin
                chk("bstart_one_cycle", prev_bstart, 1'b0);
                bstart_cyc = cyc;
                if (bs_q.size() == 0) begin
                    note_fail("unexpected_bstart");
                end else begin
                    b_item = bs_q.pop_front();
                    chk("s_addr", s_addr, b_item[66:35]);
                    chk("s_ttype", s_ttype, b_item[34]);
                    chk("s_tsize", s_tsize, b_item[33:32]);
                    if (b_item[34]) chk("s_wdata", s_wdata, b_item[31:0]);
                end
            end
            prev_bstart = s_bstart;
            if (m_done !== '0) begin
                chk("m_done_onehot", $onehot(m_done), 1'b1);
                if (exp_q.size() == 0) begin
                    note_fail("unexpected_m_done");
                end else begin
                    e_item = exp_q.pop_front();
                    chk("m_done", m_done, e_item[34:33]);
                    chk("m_err", m_err, e_item[32]);
                    chk("m_rdata", m_rdata, e_item[31:0]);
                    chk("done_latency", cyc - bstart_cyc, e_item[42:35]);
                end
            end
        end
    end

    // stimulus
    initial begin
        rst_n       = 1'b0;
        m_req       = '0;
        m_addr      = '0;
        m_ttype     = '0;
        m_tsize     = '0;
        m_wdata     = '0;
        s_rdata     = '0;
        spur_done   = 1'b0;
        slave_delay = -1;
        n_total     = 0;
        n_bad       = 0;

        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 1'b0);
        chk("rst_bstart", s_bstart, 1'b0);
        chk("rst_s_addr", s_addr, 32'h0);
        chk("rst_s_wdata", s_wdata, 32'h0);
        chk("rst_m_done", m_done, 2'b00);
        chk("rst_state", dbg_state, IDLE);
        rst_n = 1'b1;

        // single master read, slave answers 2 cycles after bstart
        @(negedge clk);
        slave_delay = 2;
        s_rdata     = 32'hDEAD_BEEF;
        set_master(0, 32'hF000_0010, READ, WORD, 32'h0);
        expect_issue(32'hF000_0010, READ, WORD, 32'h0);
        expect_done(8'd2, 2'b01, 1'b0, 32'hDEAD_BEEF);
        m_req = 2'b01;
        wait_done(2'b01, "single");
        m_req = 2'b00;
        @(negedge clk);
        chk("single_busy_after", busy, 1'b0);

        // master 1 write times out; master 0 joins and then both contend
        slave_delay = -1;
        s_rdata     = 32'h0BAD_F00D;
        set_master(1, 32'h0000_2004, WRITE, BYTE, 32'h0000_00A5);
        expect_issue(32'h0000_2004, WRITE, BYTE, 32'h0000_00A5);
        expect_done(8'd4, 2'b10, 1'b1, 32'h0);
        m_req = 2'b10;
        wait_bstart("timeout");
        set_master(0, 32'h0000_1000, READ, WORD, 32'h1111_1111);
        m_req = 2'b11;
        for (int k = 0; k < 2; k++) begin
            expect_issue(32'h0000_1000, READ, WORD, 32'h1111_1111);
            expect_done(8'd1, 2'b01, 1'b0, 32'h0BAD_F00D);
            expect_issue(32'h0000_2004, WRITE, BYTE, 32'h0000_00A5);
            expect_done(8'd1, 2'b10, 1'b0, 32'h0BAD_F00D);
        end
        wait_done(2'b10, "timeout");
        chk("timeout_busy_during", busy, 1'b1);
        slave_delay = 1;
        for (int k = 0; k < 4; k++) wait_done(2'b11, "contention");
        m_req = 2'b00;

        // s_done lands on the terminal timeout cycle
        @(negedge clk);
        slave_delay = 4;
        s_rdata     = 32'hCAFE_F00D;
        set_master(0, 32'h0000_3000, READ, HALFWORD, 32'h0);
        expect_issue(32'h0000_3000, READ, HALFWORD, 32'h0);
        expect_done(8'd4, 2'b01, 1'b0, 32'hCAFE_F00D);
        m_req = 2'b01;
        wait_done(2'b01, "same_cycle");
        m_req = 2'b00;

        // spurious s_done in IDLE, then master 0 drops while master 1 owns
        @(negedge clk);
        spur_done = 1'b1;
        #1;
        chk("spurious_no_done", m_done, 2'b00);
        @(negedge clk);
        spur_done   = 1'b0;
        slave_delay = 2;
        s_rdata     = 32'h1357_9BDF;
        set_master(1, 32'h0000_4008, WRITE, WORD, 32'h1234_5678);
        set_master(0, 32'h0000_5000, READ, WORD, 32'h0);
        expect_issue(32'h0000_4008, WRITE, WORD, 32'h1234_5678);
        expect_done(8'd2, 2'b10, 1'b0, 32'h1357_9BDF);
        m_req = 2'b11;
        wait_bstart("drop");
        m_req[0] = 1'b0;
        wait_done(2'b10, "drop");
        m_req = 2'b00;
        repeat (3) @(negedge clk);
        chk("drop_busy_after", busy, 1'b0);

        // master 0 completes, then a second master 0 transaction is reset in WAIT
        slave_delay = 1;
        s_rdata     = 32'h2468_ACE0;
        set_master(0, 32'h0000_6000, READ, WORD, 32'h0);
        expect_issue(32'h0000_6000, READ, WORD, 32'h0);
        expect_done(8'd1, 2'b01, 1'b0, 32'h2468_ACE0);
        m_req = 2'b01;
        wait_done(2'b01, "pre_reset");
        m_req = 2'b00;
        @(negedge clk);
        slave_delay = -1;
        expect_issue(32'h0000_6000, READ, WORD, 32'h0);
        m_req = 2'b01;
        wait_bstart("reset");
        @(negedge clk);
        #1 rst_n = 1'b0;
        #0.5;
        chk("reset_busy", busy, 1'b0);
        chk("reset_bstart", s_bstart, 1'b0);
        chk("reset_state", dbg_state, IDLE);
        chk("reset_m_done", m_done, 2'b00);
        slave_delay = 1;
        m_req       = 2'b11;
        set_master(1, 32'h0000_7000, READ, BYTE, 32'h0);
        expect_issue(32'h0000_6000, READ, WORD, 32'h0);
        expect_done(8'd1, 2'b01, 1'b0, 32'h2468_ACE0);
        expect_issue(32'h0000_7000, READ, BYTE, 32'h0);
        expect_done(8'd1, 2'b10, 1'b0, 32'h2468_ACE0);
        #0.5 rst_n = 1'b1;
        wait_done(2'b01, "post_reset_m0");
        m_req[0] = 1'b0;
        wait_done(2'b10, "post_reset_m1");
        m_req = 2'b00;

        repeat (4) @(negedge clk);
        chk("exp_q_drained", exp_q.size(), 0);
        chk("bs_q_drained", bs_q.size(), 0);
        chk("final_busy", busy, 1'b0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
